// File: rtl/am_demod.sv
// AM envelope demodulator: quadrature NCO mixer, per-arm 3-stage CIC decimator,
// alpha-max/beta-min magnitude estimate updated once per decimated sample.

module am_demod_cic #(
  parameter int IN_W   = 17,
  parameter int DEC_LG = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stb,
  input  logic signed [IN_W-1:0] i_x,
  output logic signed [IN_W-1:0] o_y
);
  localparam int W = IN_W + 3 * DEC_LG;

  logic [2:0][W-1:0] r_int, r_dly;
  logic [W-1:0]      w_c1, w_c2, w_c3;
  logic signed [W-1:0] w_cs;

  // Integrators wrap freely; the combs recover the exact result modulo 2^W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int <= '0;
      r_dly <= '0;
    end else begin
      r_int[0] <= r_int[0] + W'(i_x);
      r_int[1] <= r_int[1] + r_int[0];
      r_int[2] <= r_int[2] + r_int[1];
      if (i_stb) begin
        r_dly[0] <= r_int[2];
        r_dly[1] <= w_c1;
        r_dly[2] <= w_c2;
      end
    end
  end

  assign w_c1 = r_int[2] - r_dly[0];
  assign w_c2 = w_c1 - r_dly[1];
  assign w_c3 = w_c2 - r_dly[2];
  assign w_cs = w_c3;
  assign o_y  = IN_W'(w_cs >>> (3 * DEC_LG));
endmodule

module am_demod #(
  parameter int          ADC_W   = 14,
  parameter int          OUT_W   = 18,
  parameter logic [31:0] PHI_INC = 32'd343597384,
  parameter int          DEC     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ADC_W-1:0] adc_data,
  output logic signed [OUT_W-1:0] demod_out,
  output logic                    demod_clk
);
  localparam int NCO_W  = 16;
  localparam int PW     = ADC_W + NCO_W;
  localparam int MIX_SH = ADC_W - 1;
  localparam int MIX_W  = PW - MIX_SH;
  localparam int DEC_LG = $clog2(DEC);
  localparam int SUM_W  = ((OUT_W > MIX_W + 1) ? OUT_W : MIX_W + 1) + 2;
  localparam logic signed [PW-1:0] MIX_MAX = PW'(2 ** (NCO_W - 1) - 1);
  localparam logic [SUM_W-1:0]     OUT_MAX = SUM_W'(2 ** (OUT_W - 1) - 1);

  // round(32767*sin(pi/2*k/256)) via a Q30 Horner-form Taylor series.
  function automatic logic [NCO_W-1:0] sin_q(input int k);
    longint x, x2, t;
    x  = (64'sd3373259426 * longint'(k)) / 512;
    x2 = (x * x) >>> 30;
    t  = 64'sd1 <<< 30;
    for (int n = 15; n >= 3; n -= 2)
      t = (64'sd1 <<< 30) - ((x2 * t) >>> 30) / longint'(n * (n - 1));
    return NCO_W'((32767 * ((x * t) >>> 30) + (64'sd1 <<< 29)) >>> 30);
  endfunction

  logic [31:0]                   r_ph;
  logic [1:0][NCO_W-1:0]         r_nco;   // [0] sin, [1] cos
  logic signed [ADC_W-1:0]       r_adc;
  logic [1:0][MIX_W-1:0]         r_mix;   // [0] I, [1] Q
  logic [DEC_LG-1:0]             r_cnt;
  logic                          r_dclk;
  logic signed [OUT_W-1:0]       r_out;

  logic [NCO_W-1:0]              w_rom [256];
  logic [1:0][9:0]               w_addr;
  logic [1:0][NCO_W-1:0]         w_wave;
  logic [1:0][MIX_W-1:0]         w_mix_d, w_y;
  logic [1:0][MIX_W:0]           w_abs;
  logic [MIX_W:0]                w_max, w_min;
  logic [SUM_W-1:0]              w_sum;
  logic [OUT_W-1:0]              w_mag;
  logic [DEC_LG-1:0]             w_cnt_nxt;
  logic                          w_stb;

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [NCO_W-1:0] V = sin_q(k);
    assign w_rom[k] = V;
  end

  assign w_addr[0] = r_ph[31:22];
  assign w_addr[1] = r_ph[31:22] + 10'd256;

  // Quarter-wave symmetry: mirror the index in odd quadrants, negate in the lower half.
  for (genvar g = 0; g < 2; g++) begin : g_nco
    logic [7:0]       w_idx, w_mir;
    logic [NCO_W-1:0] w_amp;
    assign w_idx     = w_addr[g][7:0];
    assign w_mir     = w_addr[g][8] ? (~w_idx + 8'd1) : w_idx;
    assign w_amp     = (w_addr[g][8] && w_idx == 8'd0) ? NCO_W'(32767) : w_rom[w_mir];
    assign w_wave[g] = w_addr[g][9] ? -w_amp : w_amp;
  end

  for (genvar g = 0; g < 2; g++) begin : g_arm
    logic signed [PW-1:0] w_prod, w_sh;
    logic signed [MIX_W:0] w_ext;
    assign w_prod     = PW'(r_adc) * PW'($signed(r_nco[1-g]));
    assign w_sh       = ((g == 0) ? w_prod : -w_prod) >>> MIX_SH;
    assign w_mix_d[g] = (w_sh > MIX_MAX) ? MIX_W'(MIX_MAX) : w_sh[MIX_W-1:0];

    am_demod_cic #(.IN_W(MIX_W), .DEC_LG(DEC_LG)) u_cic (
      .clk  (clk),
      .rst  (rst),
      .i_stb(w_stb),
      .i_x  (r_mix[g]),
      .o_y  (w_y[g])
    );

    assign w_ext    = {w_y[g][MIX_W-1], w_y[g]};
    assign w_abs[g] = w_ext[MIX_W] ? -w_ext : w_ext;
  end

  assign w_max = (w_abs[0] >= w_abs[1]) ? w_abs[0] : w_abs[1];
  assign w_min = (w_abs[0] >= w_abs[1]) ? w_abs[1] : w_abs[0];
  assign w_sum = SUM_W'(w_max) + SUM_W'(w_min >> 2) + SUM_W'(w_min >> 3);
  assign w_mag = (w_sum > OUT_MAX) ? OUT_MAX[OUT_W-1:0] : w_sum[OUT_W-1:0];

  assign w_cnt_nxt = r_cnt + DEC_LG'(1);
  assign w_stb     = (r_cnt == DEC_LG'(DEC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ph   <= '0;
      r_nco  <= '0;
      r_adc  <= '0;
      r_mix  <= '0;
      r_cnt  <= '0;
      r_dclk <= 1'b1;
      r_out  <= '0;
    end else begin
      r_ph   <= r_ph + PHI_INC;
      r_nco  <= w_wave;
      r_adc  <= adc_data;
      r_mix  <= w_mix_d;
      r_cnt  <= w_cnt_nxt;
      r_dclk <= (w_cnt_nxt < DEC_LG'(DEC / 2));
      if (w_stb) r_out <= w_mag;
    end
  end

  assign demod_out = r_out;
  assign demod_clk = r_dclk;
endmodule

// File: tb/tb_am_demod.sv
// Bench for am_demod: FIR-equivalent (boxcar^3) reference model checked every cycle,
// plus literal range checks for carrier, off-frequency, zero and full-scale stimulus.

module tb_am_demod;
  localparam int     DEC = 16;
  localparam longint INC = 343597384;
  localparam real    PI2 = 6.283185307179586;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [13:0]  adc_data = '0;
  logic signed [17:0]  demod_out;
  logic                demod_clk;

  am_demod dut (
    .clk      (clk),
    .rst      (rst),
    .adc_data (adc_data),
    .demod_out(demod_out),
    .demod_clk(demod_clk)
  );

  always #4 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     n = 0;
  int     sin_tab [1024];
  int     b [46];
  longint mi [32768];
  longint mq [32768];
  longint exp_out = 0;
  longint lo, hi;
  int     xcnt;

  function automatic int rnd(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, n);
    end
  endtask

  // Cascade of three length-DEC moving sums with zero history, scaled by 2^-12.
  function automatic longint model_out(input int c);
    longint si = 0, sq = 0, ai, aq, mx, mn, mag;
    for (int j = 0; j < 46; j++) begin
      if (c - 5 - j >= 0) begin
        si += b[j] * mi[c-5-j];
        sq += b[j] * mq[c-5-j];
      end
    end
    ai = si >>> 12; aq = sq >>> 12;
    if (ai < 0) ai = -ai;
    if (aq < 0) aq = -aq;
    mx = (ai > aq) ? ai : aq;
    mn = (ai > aq) ? aq : ai;
    mag = mx + (mn >> 2) + (mn >> 3);
    if (mag > 131071) mag = 131071;
    return mag;
  endfunction

  always @(negedge clk) begin
    longint a, x, v;
    if (rst) begin
      n = 0;
      exp_out = 0;
    end else if (n < 32768) begin
      a = ((longint'(n) * INC) & 64'hFFFFFFFF) >> 22;
      x = adc_data;
      v = (x * sin_tab[(a + 256) & 1023]) >>> 13;
      mi[n] = (v > 32767) ? 32767 : v;
      v = (-(x * sin_tab[a])) >>> 13;
      mq[n] = (v > 32767) ? 32767 : v;
      if (n > 0 && n % DEC == 0) exp_out = model_out(n - 1);
      check("demod_out", longint'(demod_out), exp_out);
      check("demod_clk", longint'(demod_clk), longint'((n % DEC) < DEC / 2));
      check("out_known", longint'($isunknown({demod_out, demod_clk})), 0);
      n++;
    end
  end

  // mode 0 zero, 1 10 MHz carrier, 2 30 MHz carrier, 3 random, 4 full-scale square on carrier
  task automatic run(input int mode, input int ncyc, input int amp, input int win);
    lo = 64'sd1 <<< 40; hi = -(64'sd1 <<< 40); xcnt = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk); #1;
      if (i >= win) begin
        if ($isunknown(demod_out)) xcnt++;
        if (longint'(demod_out) < lo) lo = demod_out;
        if (longint'(demod_out) > hi) hi = demod_out;
      end
      case (mode)
        1:       adc_data = 14'(rnd(amp * $cos(PI2 * 0.08 * n)));
        2:       adc_data = 14'(rnd(amp * $cos(PI2 * 0.24 * n)));
        3:       adc_data = ($urandom_range(0, 7) == 0) ? -14'sd8192 : 14'($urandom);
        4:       adc_data = ($cos(PI2 * 0.08 * n) >= 0.0) ? 14'sd8191 : -14'sd8192;
        default: adc_data = '0;
      endcase
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) sin_tab[a] = rnd(32767.0 * $sin(PI2 * a / 1024.0));
    for (int j = 0; j < 46; j++) begin
      b[j] = 0;
      for (int p = 0; p < 16; p++)
        for (int q = 0; q < 16; q++)
          if (j - p - q >= 0 && j - p - q < 16) b[j]++;
    end
    check("tab_sin0", sin_tab[0], 0);
    check("tab_sin128", sin_tab[128], 23170);
    check("tab_sin256", sin_tab[256], 32767);
    check("tab_sin768", sin_tab[768], -32767);
    begin
      int s = 0;
      for (int j = 0; j < 46; j++) s += b[j];
      check("fir_gain", s, 4096);
    end
    check("fir_b0", b[0], 1);
    check("fir_b22", b[22], 192);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_out", longint'(demod_out), 0);
    check("rst_dclk", longint'(demod_clk), 1);

    run(0, 2000, 0, 0);
    check("zero_max", hi, 0);
    check("zero_min", lo, 0);

    run(1, 600, 100, 200);
    checks++;
    if (!(lo >= 194 && hi <= 214 && hi - lo <= 2)) begin
      errors++;
      $display("FAIL carrier_range: min %0d max %0d, required within 194..214 and ripple <= 2", lo, hi);
    end

    run(2, 600, 1000, 200);
    checks++;
    if (hi > 20) begin
      errors++;
      $display("FAIL offfreq_reject: max %0d, required <= 20", hi);
    end

    run(3, 700, 0, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    adc_data = 14'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_out", longint'(demod_out), 0);
    check("midrst_dclk", longint'(demod_clk), 1);
    run(3, 500, 0, 0);

    run(4, 600, 0, 0);
    check("fs_nonneg", lo >= 0, 1);
    check("fs_sat", hi <= 131071, 1);
    check("fs_known", xcnt, 0);

    run(0, 200, 0, 150);
    check("tail_zero", hi, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
